// File: rtl/instruction_fetch.sv
// Fetch stage: walks the PC over the byte-wide ROM, assembles 1/2-byte
// instructions and hands them to decode. Optional self-loop halt: IFETCH_HALT_DETECT_EN.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic       instr_two_byte,
    output logic [7:0] instr_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_target,
    output logic       halted
);

`ifdef IFETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {BYTE0, BYTE1, VALID, HALT} state_t;
`else
    typedef enum logic [1:0] {BYTE0, BYTE1, VALID} state_t;
`endif

    state_t     state, state_n;
    logic [7:0] pc, pc_n;
    logic [7:0] opcode_n, operand_n, ipc_n;
    logic       two_n;
    logic       in_halt;

    // MOV_IMM / CMP_IMM (8x) and the branches (Ax/Bx) carry an operand byte
    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7:4] == 4'b1000) || (b[7:5] == 3'b101);
    endfunction

    assign mem_addr = pc;

`ifdef IFETCH_HALT_DETECT_EN
    logic halted_q;
    assign in_halt = (state == HALT);
    assign halted  = halted_q;
`else
    assign in_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        opcode_n  = instr_opcode;
        operand_n = instr_operand;
        two_n     = instr_two_byte;
        ipc_n     = instr_pc;
        case (state)
            BYTE0: begin
                opcode_n = mem_data;
                ipc_n    = pc;
                pc_n     = pc + 8'd1;
                two_n    = is_two_byte(mem_data);
                if (is_two_byte(mem_data)) begin
                    state_n = BYTE1;
                end else begin
                    operand_n = 8'h00;
                    state_n   = VALID;
                end
            end
            BYTE1: begin
                operand_n = mem_data;
                pc_n      = pc + 8'd1;
                state_n   = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    state_n = BYTE0;
`ifdef IFETCH_HALT_DETECT_EN
                    // BRA to itself: park instead of spinning forever
                    if (instr_opcode == 8'hA8 && instr_operand == instr_pc)
                        state_n = HALT;
`endif
                end
            end
            default: state_n = state;
        endcase
        // redirect wins over every transition, including the halt entry
        if (redirect && !in_halt) begin
            pc_n    = redirect_target;
            state_n = BYTE0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BYTE0;
            pc             <= RESET_PC;
            instr_valid    <= 1'b0;
            instr_opcode   <= 8'h00;
            instr_operand  <= 8'h00;
            instr_two_byte <= 1'b0;
            instr_pc       <= 8'h00;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            instr_valid    <= (state_n == VALID);
            instr_opcode   <= opcode_n;
            instr_operand  <= operand_n;
            instr_two_byte <= two_n;
            instr_pc       <= ipc_n;
        end
    end

`ifdef IFETCH_HALT_DETECT_EN
    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b0;
        else if (state_n == HALT) halted_q <= 1'b1;
    end
`endif

endmodule
